wb_master_seq_mem_access: RTL and testbench
===========================================

Name: wb_master_seq_mem_access

Overview:
Wishbone classic (B3) bus master that walks a memory window sequentially from START_ADDR to END_ADDR in STEP increments. At each address it performs one single write, then one single read-back of the same address, and compares the returned data against what it wrote. It is a built-in memory/slave exerciser sitting directly on a Wishbone slave port, and it reports results through sticky status flags.

Parameters:
ADDR_WIDTH, 16, width of adr_o.
DATA_WIDTH, 32, width of dat_o/dat_i; must be >= ADDR_WIDTH.
START_ADDR, 0, first word address of the window.
END_ADDR, 7, last word address of the window; must be >= START_ADDR.
STEP, 1, address increment per word; must be >= 1.

Ports:
clk_i  in  1  system clock; all logic on rising edge
rst_i  in  1  reset, asynchronous, active-low
stb_o  out  1  Wishbone strobe
cyc_o  out  1  Wishbone cycle; always equal to stb_o
we_o  out  1  1 = write phase, 0 = read phase
adr_o  out  ADDR_WIDTH  word address
dat_o  out  DATA_WIDTH  write data
dat_i  in  DATA_WIDTH  read data
ack_i  in  1  slave acknowledge
err_i  in  1  slave error termination
mismatch_o  out  1  sticky: a read-back differed from the written data
bus_err_o  out  1  sticky: err_i terminated a phase
done_o  out  1  window complete (see Optional Feature)

Behaviour:
- Reset (rst_i = 0, asynchronous) drives:
  - stb_o = cyc_o = we_o = 0, dat_o = 0, adr_o = START_ADDR.
  - mismatch_o = bus_err_o = done_o = 0.
  - Internal pass counter = 0; state = IDLE.
- State sequence: IDLE -> WR -> WR_GAP -> RD -> RD_GAP -> WR ...
- IDLE: lasts one cycle after reset release; outputs stay idle.
- WR state:
  - Drives stb_o = cyc_o = we_o = 1, with adr_o = current address and dat_o = pattern.
  - Holds all of these stable until ack_i or err_i is sampled high at a rising edge; then moves to WR_GAP.
- WR_GAP: stb_o = cyc_o = 0 for exactly one cycle; adr_o is held.
- RD state:
  - Drives stb_o = cyc_o = 1, we_o = 0, with the same adr_o.
  - When ack_i is sampled high, captures dat_i and compares it with the pattern; any inequality sets mismatch_o.
  - err_i also terminates the phase, sets bus_err_o, and performs no compare.
  - A write phase ended by err_i also sets bus_err_o, but the read still follows.
- If ack_i and err_i are high together, err_i wins.
- RD_GAP:
  - stb_o = cyc_o = 0 for one cycle.
  - Address advances. The next address is computed in ADDR_WIDTH+1 bits as adr + STEP.
  - If the current address == END_ADDR, or the sum > END_ADDR, the address wraps to START_ADDR and the pass counter increments (modulo its width).
- Pattern:
  - The low ADDR_WIDTH bits are the current address.
  - The remaining upper DATA_WIDTH-ADDR_WIDTH bits are the pass counter.
  - When DATA_WIDTH == ADDR_WIDTH, the pattern is the address only.
- Timing: with a zero-wait-state slave (ack_i combinational from stb_o), each word takes 4 clocks (WR, WR_GAP, RD, RD_GAP). Wait states extend WR/RD indefinitely; there is no timeout.
- Strobe behaviour: stb_o always returns low between phases, so every phase begins with a rising stb_o edge.
- ack_i/err_i sampled while stb_o = 0 are ignored.
- Reset mid-phase: outputs drop immediately, and the sequence restarts at START_ADDR with the pass counter at 0.
- Sticky flags clear only on reset.

Optional Feature:
WB_SEQ_ONESHOT_EN:
- Defined:
  - Instead of wrapping after the read of the last address, the master enters DONE.
  - DONE holds stb_o = cyc_o = 0 and asserts done_o = 1 until reset.
  - Only a single pass (pass counter 0) ever occurs.
- Undefined:
  - The master wraps and loops forever.
  - done_o is tied to 0.

Test Plan:
- Defaults, zero-wait echo slave (ack on stb, read returns last written data), 16 write/read pairs:
  - Addresses 0..7 are written with 0x00000000..0x00000007.
  - Then 0..7 again with 0x00010000..0x00010007.
  - we_o = 1 then 0 at each address; mismatch_o = 0; bus_err_o = 0.
- Slave returns 0xDEADBEEF on the read of address 3 -> mismatch_o rises after that read and stays 1.
- err_i instead of ack_i on the write to address 2:
  - bus_err_o = 1.
  - The read of address 2 still occurs, then the walk continues to address 3.
- START_ADDR = 0, END_ADDR = 7, STEP = 3 -> addresses 0, 3, 6, then wrap to 0 with pass counter = 1.
- Slave inserts 3 wait states -> stb_o, adr_o and dat_o stay stable for 4 clocks per phase; stb_o is low 1 clock between phases.
- Reset asserted during the read of address 5, and separately with WB_SEQ_ONESHOT_EN defined:
  - Reset: outputs go idle asynchronously, and the restart begins at address 0 with pattern 0x00000000.
  - WB_SEQ_ONESHOT_EN: done_o = 1 after the read of address 7, with no further strobes.

Source files
------------

// File: rtl/wb_master_seq_mem_access.sv
// Wishbone classic master that walks a memory window, writing then reading back each word.
// Optional build macro WB_SEQ_ONESHOT_EN: stop in DONE after one pass instead of wrapping forever.
module wb_master_seq_mem_access #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 7,
  parameter int STEP       = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  stb_o,
  output logic                  cyc_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i,
  input  logic                  err_i,
  output logic                  mismatch_o,
  output logic                  bus_err_o,
  output logic                  done_o
);

  localparam int PASS_WIDTH = (DATA_WIDTH > ADDR_WIDTH) ? (DATA_WIDTH - ADDR_WIDTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH:0]   END_EXT  = (ADDR_WIDTH + 1)'(END_ADDR);
  localparam logic [ADDR_WIDTH:0]   STEP_EXT = (ADDR_WIDTH + 1)'(STEP);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    WR_GAP = 3'd2,
    RD     = 3'd3,
    RD_GAP = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                  state;
  logic [PASS_WIDTH-1:0]   pass_cnt;
  logic [ADDR_WIDTH:0]     adr_sum;
  logic                    wrap;
  logic [ADDR_WIDTH-1:0]   adr_next;
  logic [PASS_WIDTH-1:0]   pass_next;

  // Pass counter sits above the address bits; with no spare bits the shift drops it entirely.
  function automatic logic [DATA_WIDTH-1:0] make_pattern(input logic [PASS_WIDTH-1:0] p,
                                                         input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] r;
    r = DATA_WIDTH'(a);
    if (DATA_WIDTH > ADDR_WIDTH) begin
      r = r | (DATA_WIDTH'(p) << ADDR_WIDTH);
    end
    return r;
  endfunction

  always_comb begin
    adr_sum   = {1'b0, adr_o} + STEP_EXT;
    wrap      = ({1'b0, adr_o} == END_EXT) || (adr_sum > END_EXT);
    adr_next  = wrap ? START_A : adr_sum[ADDR_WIDTH-1:0];
    pass_next = wrap ? (pass_cnt + 1'b1) : pass_cnt;
  end

  assign cyc_o = stb_o;

`ifdef WB_SEQ_ONESHOT_EN
  logic done_reg;
  assign done_o = done_reg;
`else
  assign done_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      stb_o      <= 1'b0;
      we_o       <= 1'b0;
      adr_o      <= START_A;
      dat_o      <= '0;
      pass_cnt   <= '0;
      mismatch_o <= 1'b0;
      bus_err_o  <= 1'b0;
`ifdef WB_SEQ_ONESHOT_EN
      done_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state <= WR;
          stb_o <= 1'b1;
          we_o  <= 1'b1;
          dat_o <= make_pattern(pass_cnt, adr_o);
        end
        WR: begin
          if (ack_i || err_i) begin
            if (err_i) bus_err_o <= 1'b1;
            state <= WR_GAP;
            stb_o <= 1'b0;
          end
        end
        WR_GAP: begin
          state <= RD;
          stb_o <= 1'b1;
          we_o  <= 1'b0;
        end
        RD: begin
          // dat_o still holds the pattern written to this address.
          if (ack_i || err_i) begin
            if (err_i) begin
              bus_err_o <= 1'b1;
            end else if (dat_i != dat_o) begin
              mismatch_o <= 1'b1;
            end
            state <= RD_GAP;
            stb_o <= 1'b0;
          end
        end
        RD_GAP: begin
`ifdef WB_SEQ_ONESHOT_EN
          if (wrap) begin
            state    <= DONE;
            done_reg <= 1'b1;
          end else begin
            state    <= WR;
            stb_o    <= 1'b1;
            we_o     <= 1'b1;
            adr_o    <= adr_next;
            pass_cnt <= pass_next;
            dat_o    <= make_pattern(pass_next, adr_next);
          end
`else
          state    <= WR;
          stb_o    <= 1'b1;
          we_o     <= 1'b1;
          adr_o    <= adr_next;
          pass_cnt <= pass_next;
          dat_o    <= make_pattern(pass_next, adr_next);
`endif
        end
        DONE: begin
          state <= DONE;
          stb_o <= 1'b0;
        end
        default: begin
          state <= IDLE;
          stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_seq_mem_access.sv
// Bench for wb_master_seq_mem_access: phase-level model checked every cycle, plus literal anchors.
`timescale 1ns/1ps
module tb_wb_master_seq_mem_access;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int N_WORDS = 8;
  localparam int ONESHOT_PHASES = 2 * N_WORDS;

  logic clk_i = 1'b0;
  logic rst_i, rst3;
  always #5 clk_i = ~clk_i;

  logic          stb, cyc, we, ack, err, mis, berr, done;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat, dat_in;

  logic          stb3, cyc3, we3, ack3, err3, mis3, berr3, done3;
  logic [AW-1:0] adr3;
  logic [DW-1:0] dat3, dat3_in;

  wb_master_seq_mem_access dut (
    .clk_i(clk_i), .rst_i(rst_i), .stb_o(stb), .cyc_o(cyc), .we_o(we), .adr_o(adr),
    .dat_o(dat), .dat_i(dat_in), .ack_i(ack), .err_i(err), .mismatch_o(mis),
    .bus_err_o(berr), .done_o(done)
  );

  wb_master_seq_mem_access #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .START_ADDR(0), .END_ADDR(7), .STEP(3)) dut3 (
    .clk_i(clk_i), .rst_i(rst3), .stb_o(stb3), .cyc_o(cyc3), .we_o(we3), .adr_o(adr3),
    .dat_o(dat3), .dat_i(dat3_in), .ack_i(ack3), .err_i(err3), .mismatch_o(mis3),
    .bus_err_o(berr3), .done_o(done3)
  );

  // Echo slave with programmable wait states and fault injection
  int waits = 0;
  bit err_on = 1'b0;
  bit corrupt_on = 1'b0;
  int wcnt = 0;
  logic [DW-1:0] mem [0:15];
  logic [DW-1:0] mem3 [0:15];
  wire ready = stb && (wcnt == waits);

  assign err     = ready && err_on && we && (adr == 16'd2);
  assign ack     = ready && !err;
  assign dat_in  = (corrupt_on && !we && adr == 16'd3) ? 32'hDEADBEEF : mem[adr[3:0]];
  assign ack3    = stb3;
  assign err3    = 1'b0;
  assign dat3_in = mem3[adr3[3:0]];

  always @(posedge clk_i) begin
    if (!stb || ack || err) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (stb && we && ack) mem[adr[3:0]] <= dat;
    if (stb3 && we3 && ack3) mem3[adr3[3:0]] <= dat3;
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } phase_t;

  phase_t log_q[$];
  phase_t log3_q[$];
  int vectors = 0;
  int miscompares = 0;
  int k = 0, low_cnt = 0, hi_cnt = 0, last_len = 0;
  bit in_phase = 1'b0, exp_mis = 1'b0, exp_berr = 1'b0, exp_done = 1'b0;
  logic prev_stb3 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Phase idx: word idx/2, write on even idx, read on odd; pass = word / window length.
  function automatic logic [AW-1:0] model_adr(input int idx);
    return AW'((idx / 2) % N_WORDS);
  endfunction

  function automatic logic [DW-1:0] model_dat(input int idx);
    logic [15:0] p;
    p = 16'((idx / 2) / N_WORDS);
    return {p, model_adr(idx)};
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i) begin
      k = 0; low_cnt = 0; hi_cnt = 0; in_phase = 1'b0;
      exp_mis = 1'b0; exp_berr = 1'b0;
      log_q.delete();
    end else begin
      chk("cyc_eq_stb", cyc, stb);
      chk("mismatch_flag", mis, exp_mis);
      chk("bus_err_flag", berr, exp_berr);
      if (stb) begin
        if (!in_phase) begin
          if (k > 0) chk("gap_len", low_cnt, 1);
`ifdef WB_SEQ_ONESHOT_EN
          chk("no_extra_strobe", k < ONESHOT_PHASES, 1);
`endif
          log_q.push_back('{we, adr, dat});
          in_phase = 1'b1;
          hi_cnt = 0;
        end
        chk($sformatf("we[%0d]", k), we, (k % 2) == 0);
        chk($sformatf("adr[%0d]", k), adr, model_adr(k));
        if ((k % 2) == 0) chk($sformatf("dat[%0d]", k), dat, model_dat(k));
        hi_cnt++;
        if (ack || err) begin
          if (err) exp_berr = 1'b1;
          else if ((k % 2) == 1 && dat_in != model_dat(k)) exp_mis = 1'b1;
          k++;
          in_phase = 1'b0;
          last_len = hi_cnt;
          low_cnt = 0;
        end
        exp_done = 1'b0;
      end else begin
        if (in_phase) begin
          chk("stb_held", stb, 1);
          in_phase = 1'b0;
        end
        low_cnt++;
`ifdef WB_SEQ_ONESHOT_EN
        exp_done = (k >= ONESHOT_PHASES) && (low_cnt >= 2);
`else
        exp_done = 1'b0;
`endif
      end
      chk("done", done, exp_done);
    end
  end

  always @(negedge clk_i) begin
    if (rst3 && stb3 && !prev_stb3 && log3_q.size() < 8) log3_q.push_back('{we3, adr3, dat3});
    prev_stb3 <= stb3;
  end

  task automatic wait_phases(input int n, input int budget);
    for (int c = 0; c < budget && k < n; c++) @(negedge clk_i);
    chk($sformatf("timeout_waiting_%0d_phases", n), k >= n, 1);
  endtask

  task automatic do_reset(input int w, input bit e, input bit c);
    @(negedge clk_i);
    #1 rst_i = 1'b0;
    waits = w; err_on = e; corrupt_on = c;
    repeat (2) @(negedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  task automatic chk_log(input string nm, input int idx, input logic we_e,
                         input logic [AW-1:0] a_e, input logic [DW-1:0] d_e);
    if (idx >= log_q.size()) begin
      chk({nm, "_present"}, log_q.size(), idx + 1);
    end else begin
      chk({nm, "_we"}, log_q[idx].we, we_e);
      chk({nm, "_adr"}, log_q[idx].adr, a_e);
      if (we_e) chk({nm, "_dat"}, log_q[idx].dat, d_e);
    end
  endtask

  task automatic chk_log3(input string nm, input int idx, input logic [AW-1:0] a_e,
                          input logic [DW-1:0] d_e);
    if (idx >= log3_q.size()) begin
      chk({nm, "_present"}, log3_q.size(), idx + 1);
    end else begin
      chk({nm, "_we"}, log3_q[idx].we, 1);
      chk({nm, "_adr"}, log3_q[idx].adr, a_e);
      chk({nm, "_dat"}, log3_q[idx].dat, d_e);
    end
  endtask

  initial begin
    bit hit;
    rst_i = 1'b0;
    rst3  = 1'b0;
    #3;
    chk("rst_stb", stb, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_we", we, 0);
    chk("rst_adr", adr, 0);
    chk("rst_dat", dat, 0);
    chk("rst_mis", mis, 0);
    chk("rst_berr", berr, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk_i);
    #1 rst_i = 1'b1;
    rst3 = 1'b1;

    // Clean walk with zero-wait echo slave
`ifdef WB_SEQ_ONESHOT_EN
    wait_phases(ONESHOT_PHASES, 200);
    repeat (6) @(negedge clk_i);
    chk("oneshot_done", done, 1);
    chk("oneshot_stb_idle", stb, 0);
    chk("oneshot_phase_count", log_q.size(), 16);
    chk_log("a_p0", 0, 1, 16'd0, 32'h0);
    chk_log("a_p6", 6, 1, 16'd3, 32'h3);
    chk_log("a_p15", 15, 0, 16'd7, 32'h0);
    chk("step3_done", done3, 1);
    chk("step3_phase_count", log3_q.size(), 6);
    chk_log3("s3_w0", 0, 16'd0, 32'h0);
    chk_log3("s3_w1", 2, 16'd3, 32'h3);
    chk_log3("s3_w2", 4, 16'd6, 32'h6);
`else
    wait_phases(32, 300);
    chk_log("a_p0", 0, 1, 16'd0, 32'h00000000);
    chk_log("a_p1", 1, 0, 16'd0, 32'h0);
    chk_log("a_p6", 6, 1, 16'd3, 32'h00000003);
    chk_log("a_p16", 16, 1, 16'd0, 32'h00010000);
    chk_log("a_p30", 30, 1, 16'd7, 32'h00010007);
    chk_log("a_p31", 31, 0, 16'd7, 32'h0);
    chk("step3_done", done3, 0);
    chk_log3("s3_w0", 0, 16'd0, 32'h00000000);
    chk_log3("s3_w1", 2, 16'd3, 32'h00000003);
    chk_log3("s3_w2", 4, 16'd6, 32'h00000006);
    chk_log3("s3_wrap", 6, 16'd0, 32'h00010000);
`endif
    chk("a_mis", mis, 0);
    chk("a_berr", berr, 0);

    // Corrupted read-back of address 3
    do_reset(0, 1'b0, 1'b1);
    wait_phases(10, 100);
    chk_log("b_rd3", 7, 0, 16'd3, 32'h0);
    chk("b_mis_sticky", mis, 1);
    chk("b_berr", berr, 0);

    // Error termination of the write to address 2
    do_reset(0, 1'b1, 1'b0);
    wait_phases(8, 100);
    chk_log("c_wr2", 4, 1, 16'd2, 32'h2);
    chk_log("c_rd2", 5, 0, 16'd2, 32'h0);
    chk_log("c_wr3", 6, 1, 16'd3, 32'h3);
    chk("c_berr", berr, 1);
    chk("c_mis", mis, 0);

    // Three wait states per phase
    do_reset(3, 1'b0, 1'b0);
    wait_phases(6, 300);
    chk("d_phase_len", last_len, 4);
    chk_log("d_wr1", 2, 1, 16'd1, 32'h1);

    // Asynchronous reset during the read of address 5
    do_reset(0, 1'b0, 1'b0);
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk_i);
      if (stb && !we && adr == 16'd5) hit = 1'b1;
    end
    chk("e_reached_rd5", hit, 1);
    #1 rst_i = 1'b0;
    #1;
    chk("e_async_stb", stb, 0);
    chk("e_async_cyc", cyc, 0);
    chk("e_async_adr", adr, 0);
    chk("e_async_dat", dat, 0);
    repeat (2) @(negedge clk_i);
    #1 rst_i = 1'b1;
    wait_phases(2, 50);
    chk_log("e_restart", 0, 1, 16'd0, 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
